// File: rtl/display_bcd_multi_if.sv
// Operand/request and seven-segment result bundle for display_bcd_multi.
// The master drives the request side; the slave (formatter) drives the result side.
interface display_bcd_multi_if #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 8
);
  logic                  start;
  logic [WIDTH-1:0]      entrada;
  logic                  modo_hex;
  logic                  com_sinal;
  logic                  apaga_zeros;
  logic [7*DIGITS-1:0]   saida;
  logic                  ocupado;
  logic                  valido;
  logic                  estouro;

  modport master (
    output start, entrada, modo_hex, com_sinal, apaga_zeros,
    input  saida, ocupado, valido, estouro
  );

  modport slave (
    input  start, entrada, modo_hex, com_sinal, apaga_zeros,
    output saida, ocupado, valido, estouro
  );
endinterface

// File: rtl/display_bcd_multi.sv
// Multi-digit seven-segment formatter: binary-to-BCD by sequential double-dabble
// or hex pass-through, with sign, leading-zero blanking and overflow glyphs.
//
// state    | meaning
// OCIOSO   | idle, waiting for start
// CONVERTE | one shift-add-3 iteration per cycle, WIDTH cycles
// FORMATA  | one cycle: write saida/estouro, pulse valido
module display_bcd_multi #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 8
) (
  input  logic                clock,
  input  logic                resetn,
  display_bcd_multi_if.slave  bus
);

  localparam int BW = 4 * DIGITS;
  localparam int XW = (WIDTH > BW) ? WIDTH : BW;
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [6:0] GLYPH_BLANK = 7'b1111111;
  localparam logic [6:0] GLYPH_MINUS = 7'b1111110;
  localparam logic [6:0] GLYPH_E     = 7'b0110000;

  typedef enum logic [1:0] {OCIOSO, CONVERTE, FORMATA} state_t;

  state_t              state_q;
  logic [WIDTH-1:0]    mag_q;
  logic [WIDTH-1:0]    ent_q;
  logic [BW-1:0]       bcd_q;
  logic [CW-1:0]       cnt_q;
  logic                neg_q;
  logic                hex_q;
  logic                blank_q;
  logic                ovf_q;
  logic [7*DIGITS-1:0] saida_q;
  logic                ocupado_q;
  logic                valido_q;
  logic                estouro_q;

  logic                neg_d;
  logic [WIDTH-1:0]    mag_d;
  logic [BW-1:0]       bcd_d;
  logic [XW-1:0]       ent_ext;
  logic [3:0]          nib [DIGITS];
  logic [7*DIGITS-1:0] saida_d;
  logic                estouro_d;
  int                  msd;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'b0000001;
      4'h1: glyph = 7'b1001111;
      4'h2: glyph = 7'b0010010;
      4'h3: glyph = 7'b0000110;
      4'h4: glyph = 7'b1001100;
      4'h5: glyph = 7'b0100100;
      4'h6: glyph = 7'b0100000;
      4'h7: glyph = 7'b0001111;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0000100;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b1100000;
      4'hC: glyph = 7'b0110001;
      4'hD: glyph = 7'b1000010;
      4'hE: glyph = 7'b0110000;
      default: glyph = 7'b0111000;
    endcase
  endfunction

  assign neg_d   = bus.com_sinal & bus.entrada[WIDTH-1] & ~bus.modo_hex;
  assign mag_d   = neg_d ? (~bus.entrada + WIDTH'(1)) : bus.entrada;
  assign ent_ext = XW'(ent_q);

  // Add-3 correction applied before each shift of the double-dabble engine.
  always_comb begin
    bcd_d = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_d[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    msd       = 0;
    estouro_d = 1'b0;
    saida_d   = '1;
    for (int i = 0; i < DIGITS; i++) begin
      nib[i] = hex_q ? ent_ext[4*i +: 4] : bcd_q[4*i +: 4];
    end
    for (int i = 0; i < DIGITS; i++) begin
      if (nib[i] != 4'd0) msd = i;
    end
    if (hex_q) begin
      for (int b = 0; b < WIDTH; b++) begin
        if (b >= BW) estouro_d = estouro_d | ent_q[b];
      end
    end else begin
      estouro_d = ovf_q | (neg_q & (nib[DIGITS-1] != 4'd0)) | (neg_q & (DIGITS == 1));
    end
    // Sign takes priority over blanking; overflow overrides everything.
    for (int i = 0; i < DIGITS; i++) begin
      if (estouro_d)
        saida_d[7*i +: 7] = GLYPH_E;
      else if (neg_q && blank_q && i == msd + 1)
        saida_d[7*i +: 7] = GLYPH_MINUS;
      else if (neg_q && !blank_q && i == DIGITS - 1)
        saida_d[7*i +: 7] = GLYPH_MINUS;
      else if (blank_q && i > msd)
        saida_d[7*i +: 7] = GLYPH_BLANK;
      else
        saida_d[7*i +: 7] = glyph(nib[i]);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= OCIOSO;
      mag_q     <= '0;
      ent_q     <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      hex_q     <= 1'b0;
      blank_q   <= 1'b0;
      ovf_q     <= 1'b0;
      saida_q   <= '1;
      ocupado_q <= 1'b0;
      valido_q  <= 1'b0;
      estouro_q <= 1'b0;
    end else begin
      case (state_q)
        OCIOSO: begin
          valido_q <= 1'b0;
          if (bus.start) begin
            hex_q     <= bus.modo_hex;
            blank_q   <= bus.apaga_zeros;
            neg_q     <= neg_d;
            mag_q     <= mag_d;
            ent_q     <= bus.entrada;
            bcd_q     <= '0;
            ovf_q     <= 1'b0;
            cnt_q     <= CW'(WIDTH - 1);
            ocupado_q <= 1'b1;
            state_q   <= bus.modo_hex ? FORMATA : CONVERTE;
          end
        end
        CONVERTE: begin
          {bcd_q, mag_q} <= {bcd_d, mag_q} << 1;
          ovf_q          <= ovf_q | bcd_d[BW-1];
          if (cnt_q == '0) state_q <= FORMATA;
          else             cnt_q   <= cnt_q - CW'(1);
        end
        FORMATA: begin
          saida_q   <= saida_d;
          estouro_q <= estouro_d;
          valido_q  <= 1'b1;
          ocupado_q <= 1'b0;
          state_q   <= OCIOSO;
        end
        default: state_q <= OCIOSO;
      endcase
    end
  end

  assign bus.saida   = saida_q;
  assign bus.ocupado = ocupado_q;
  assign bus.valido  = valido_q;
  assign bus.estouro = estouro_q;

endmodule

// File: doc/display_bcd_multi.md
# display_bcd_multi

Multi-digit seven-segment formatter, the parametrised successor of the single-digit BCD decoder. It accepts a binary word on a start strobe and converts it to decimal with a sequential shift-add-3 (double-dabble) engine, or passes it through as hex nibbles. It then drives DIGITS active-low segment fields with optional sign, leading-zero blanking and overflow indication. It sits between the processor's output register and the board's seven-segment bank.

## Interface
- WIDTH, 32, binary operand width; legal range 4..32.
- DIGITS, 8, number of display digits; legal range 1..10.
- clock  in  1  system clock; all state changes on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in OCIOSO.
- entrada  in  WIDTH  operand, sampled with start.
- modo_hex  in  1  1 = hex display, 0 = decimal; sampled with start.
- com_sinal  in  1  1 = entrada is two's complement (decimal only); sampled with start.
- apaga_zeros  in  1  1 = blank leading zeros; sampled with start.
- saida  out  7*DIGITS  digit i in saida[7*i+6:7*i], bit order a..g (bit 6 = a, bit 0 = g), active-low.
- ocupado  out  1  high from the capture edge until the edge that writes saida.
- valido  out  1  one-cycle pulse coincident with a new saida.
- estouro  out  1  overflow flag for the displayed value; held until the next result.

## Operation
- States: OCIOSO, CONVERTE, FORMATA.
- Capture in OCIOSO with start=1:
  - Latch the mode bits.
  - neg = com_sinal & entrada[WIDTH-1] & ~modo_hex.
  - Magnitude = neg ? (~entrada+1) : entrada, held as a WIDTH-bit unsigned value; -2^(WIDTH-1) is legal.
  - Next state is CONVERTE in decimal mode, FORMATA in hex mode.
- CONVERTE runs WIDTH iterations. Each iteration adds 3 to every BCD nibble ≥ 5, then shifts {bcd, mag} left by 1. The BCD register is 4*DIGITS bits.
  - Sticky overflow sets if a 1 is shifted out of the top BCD nibble.
  - After the last iteration, the next state is FORMATA.
- FORMATA is one cycle and writes saida, estouro and valido, then returns to OCIOSO.
  - Digit source: the BCD nibbles in decimal mode, entrada[4*i+3:4*i] in hex mode (bits beyond WIDTH read as 0).
  - Overflow:
    - Decimal: sticky set, or neg with a nonzero top digit, or neg with DIGITS=1.
    - Hex: any nonzero entrada bit at index ≥ 4*DIGITS.
    - On overflow, every digit shows E (0110000) and estouro=1.
  - Glyphs:
    - 0..9: 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 0100000, 0001111, 0000000, 0000100.
    - A..F: 0001000, 1100000, 0110001, 1000010, 0110000, 0111000.
    - Blank: 1111111. Minus: 1111110.
  - Blanking (apaga_zeros=1): digits above the most-significant nonzero digit are blank. Digit 0 is always shown.
  - Sign:
    - If neg and apaga_zeros=1, minus goes in the digit just above the most-significant shown digit.
    - If neg and apaga_zeros=0, minus goes in digit DIGITS-1.
- start in CONVERTE or FORMATA is ignored; there is no queueing.
- saida holds its value between results.

## Timing
- Reset values: saida all 1 (blank), ocupado=0, valido=0, estouro=0, state OCIOSO. Reset mid-conversion aborts the conversion with no valido.
- Let E be the edge that samples start.
  - Decimal: saida, estouro and valido update on edge E+WIDTH+1.
  - Hex: they update on edge E+1.
- ocupado rises on E and falls on the result edge; OCIOSO is re-entered on that same edge.
- A start held high on the result edge's following cycle is accepted: back-to-back rate is WIDTH+2 cycles (decimal) or 2 cycles (hex).
- Outputs are registered only; there is no combinational path from the inputs to saida.

## Test plan
WIDTH=32, DIGITS=8 unless noted.
- Decimal, unsigned, entrada=1234, apaga_zeros=1 -> digits 3..0 = 1001111, 0010010, 0000110, 1001100, digits 7..4 blank, estouro=0, valido exactly at E+33, ocupado high for 33 cycles.
- Signed, entrada=32'hFFFFFFD3 (-45), apaga_zeros=1 -> digit2=1111110, digit1=1001100, digit0=0100100, others blank.
- Same signed input with apaga_zeros=0 -> digit7=minus, digits 6..2 = 0000001.
- Overflow: unsigned 99999999 -> all digits 0000100, estouro=0. Unsigned 100000000 -> all digits 0110000, estouro=1. Signed -10000000 -> estouro=1.
- Hex: entrada=32'hDEADBEEF, modo_hex=1 -> digits 7..0 = d,E,A,d,b,E,E,F glyphs, valido at E+1. Zero with apaga_zeros=1 -> only digit0=0000001 lit.
- Control:
  - Pulse start again 5 cycles into a conversion -> ignored, and the result is unchanged.
  - Assert resetn=0 at cycle 10 of a conversion -> saida all 1, valido never pulses.
  - After release, a new start yields a correct result.
